remote_comm: RTL and testbench

REMOTE_COMM -- requirements
Module: remote_comm

---
 rtl/remote_comm_pkg.sv | 20 ++
 rtl/uart_trx.sv | 128 ++++++++++++
 rtl/remote_comm.sv | 101 ++++++++++
 tb/tb_remote_comm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_comm_pkg.sv
// Shared constants and state encodings for the remote command link.
package remote_comm_pkg;

  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam logic [7:0] POS_ACK = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_trx.sv
// 8N1 UART transmitter and receiver sharing one clock; both run independently.
module uart_trx
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done,
  input  logic       rx_in,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  logic          tx_reg;
  logic          tx_busy_reg;
  logic          tx_done_reg;
  logic [9:0]    tx_shift_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [3:0]    tx_bit_reg;

  // Frame is {stop, data, start}; tx_reg always shows shift[0] of the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg       <= 1'b1;
      tx_busy_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
      tx_shift_reg <= '0;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
    end else begin
      tx_done_reg <= 1'b0;
      if (!tx_busy_reg) begin
        if (tx_start) begin
          tx_busy_reg  <= 1'b1;
          tx_shift_reg <= {1'b1, tx_data, 1'b0};
          tx_reg       <= 1'b0;
          tx_cnt_reg   <= '0;
          tx_bit_reg   <= '0;
        end
      end else if (tx_cnt_reg == LAST) begin
        tx_cnt_reg <= '0;
        if (tx_bit_reg == 4'd9) begin
          tx_busy_reg <= 1'b0;
          tx_done_reg <= 1'b1;
          tx_reg      <= 1'b1;
        end else begin
          tx_bit_reg   <= tx_bit_reg + 1'b1;
          tx_reg       <= tx_shift_reg[1];
          tx_shift_reg <= {1'b0, tx_shift_reg[9:1]};
        end
      end else begin
        tx_cnt_reg <= tx_cnt_reg + 1'b1;
      end
    end
  end

  assign tx      = tx_reg;
  assign tx_done = tx_done_reg;

  rx_state_t     rx_state_reg, rx_state_next;
  logic          rx_prev_reg;
  logic          rx_sample;
  logic [CW-1:0] rx_cnt_reg;
  logic [2:0]    rx_bit_reg;
  logic [7:0]    rx_shift_reg;
  logic [7:0]    rx_data_reg;
  logic          rx_rdy_reg;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_sample     = 1'b0;
    unique case (rx_state_reg)
      RX_IDLE:  if (rx_prev_reg && !rx_in) rx_state_next = RX_START;
      RX_START: if (rx_cnt_reg == HALF) begin
        rx_sample     = 1'b1;
        rx_state_next = rx_in ? RX_IDLE : RX_DATA;
      end
      RX_DATA:  if (rx_cnt_reg == LAST) begin
        rx_sample = 1'b1;
        if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
      end
      RX_STOP:  if (rx_cnt_reg == LAST) begin
        rx_sample     = 1'b1;
        rx_state_next = RX_IDLE;
      end
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // Byte is committed only when the stop bit samples high; framing errors drop it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg <= RX_IDLE;
      rx_prev_reg  <= 1'b1;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_rdy_reg   <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_prev_reg  <= rx_in;
      rx_rdy_reg   <= 1'b0;
      if (rx_state_reg == RX_IDLE || rx_sample) rx_cnt_reg <= '0;
      else rx_cnt_reg <= rx_cnt_reg + 1'b1;
      if (rx_state_reg == RX_DATA && rx_sample) begin
        rx_shift_reg <= {rx_in, rx_shift_reg[7:1]};
        rx_bit_reg   <= rx_bit_reg + 1'b1;
      end
      if (rx_state_reg == RX_STOP && rx_sample && rx_in) begin
        rx_data_reg <= rx_shift_reg;
        rx_rdy_reg  <= 1'b1;
      end
    end
  end

  assign rx_rdy  = rx_rdy_reg;
  assign rx_data = rx_data_reg;

endmodule

// File: rtl/remote_comm.sv
// Sends a 16-bit command as two UART bytes (high first) and reports response bytes.
// Optional REMOTE_COMM_RX_SYNC_EN selects a two-flop RX synchronizer instead of one flop.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  logic rx_s;

`ifdef REMOTE_COMM_RX_SYNC_EN
  logic [1:0] rx_sync_reg;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rx_sync_reg <= 2'b11;
    else       rx_sync_reg <= {rx_sync_reg[0], RX};
  end
  assign rx_s = rx_sync_reg[1];
`else
  logic rx_sync_reg;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rx_sync_reg <= 1'b1;
    else       rx_sync_reg <= RX;
  end
  assign rx_s = rx_sync_reg;
`endif

  tx_state_t   state_reg, state_next;
  logic [15:0] cmd_reg;
  logic        cmd_sent_reg;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        cmd_latch;
  logic        sent_set;

  always_comb begin
    state_next = state_reg;
    tx_start   = 1'b0;
    tx_byte    = cmd_reg[7:0];
    cmd_latch  = 1'b0;
    sent_set   = 1'b0;
    unique case (state_reg)
      IDLE: if (send_cmd) begin
        cmd_latch  = 1'b1;
        tx_start   = 1'b1;
        tx_byte    = cmd[15:8];
        state_next = HIGH;
      end
      HIGH: if (tx_done) begin
        tx_start   = 1'b1;
        state_next = LOW;
      end
      LOW: if (tx_done) begin
        sent_set   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg    <= IDLE;
      cmd_reg      <= '0;
      cmd_sent_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (cmd_latch) begin
        cmd_reg      <= cmd;
        cmd_sent_reg <= 1'b0;
      end else if (sent_set) begin
        cmd_sent_reg <= 1'b1;
      end
    end
  end

  assign cmd_sent = cmd_sent_reg;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk      (clk),
    .rst      (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_byte),
    .tx       (TX),
    .tx_done  (tx_done),
    .rx_in    (rx_s),
    .rx_rdy   (resp_rdy),
    .rx_data  (resp)
  );

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm with a short baud divisor and TX/RX scoreboards.
module tb_remote_comm;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = '0;
  logic        send_cmd = 1'b0;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [7:0] resp_exp_q[$];
  logic [7:0] resp_obs_q[$];

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst_n    (rst),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  always #5 clk = ~clk;

  // Serial decoder on TX: pushes {frame_ok, byte}; frames cut by reset are dropped.
  logic       tx_prev = 1'b1;
  logic [7:0] mon_byte;
  logic       mon_bad;
  logic       mon_ok;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx_prev && !TX) begin
        mon_bad = 1'b0;
        repeat (B / 2) begin @(negedge clk); if (rst) mon_bad = 1'b1; end
        mon_ok = (TX == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) begin @(negedge clk); if (rst) mon_bad = 1'b1; end
          mon_byte[i] = TX;
        end
        repeat (B) begin @(negedge clk); if (rst) mon_bad = 1'b1; end
        mon_ok = mon_ok && (TX == 1'b1);
        if (!mon_bad) obs_q.push_back({mon_ok, mon_byte});
      end
      tx_prev = TX;
    end
  end

  int cs_rises = 0;
  logic cs_prev = 1'b0;
  int rdy_run = 0;
  int rdy_max = 0;
  int rdy_pulses = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_sent && !cs_prev) cs_rises++;
      cs_prev = cmd_sent;
      if (resp_rdy) begin
        rdy_run++;
        if (rdy_run == 1) begin
          rdy_pulses++;
          resp_obs_q.push_back(resp);
        end
        if (rdy_run > rdy_max) rdy_max = rdy_run;
      end else begin
        rdy_run = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = stop;
    repeat (B) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_send(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  task automatic compare_tx_bytes(input int n);
    logic [8:0] got, exp;
    for (int i = 0; i < n; i++) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h0;
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL tx_byte%0d: no frame observed, expected ok=%b byte=%h", i, exp[8], exp[7:0]);
      end else begin
        got = obs_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL tx_byte%0d: got ok=%b byte=%h, expected ok=%b byte=%h",
                   i, got[8], got[7:0], exp[8], exp[7:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, expected 1", TX); end
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL reset_cmd_sent: got %b, expected 0", cmd_sent); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy: got %b, expected 0", resp_rdy); end
    checks++; if (resp !== 8'h00) begin errors++; $display("FAIL reset_resp: got %h, expected 00", resp); end
  endtask

  task automatic test_send_cmd();
    int cnt;
    exp_q.push_back({1'b1, 8'h47});
    exp_q.push_back({1'b1, 8'hF1});
    pulse_send(16'h47F1);
    cnt = 0;
    while (cmd_sent !== 1'b1 && cnt < 30 * B) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt < 20 * B - 2 || cnt > 20 * B + 2) begin
      errors++;
      $display("FAIL cmd_sent_latency: got %0d clocks, expected %0d +/-2", cnt, 20 * B);
    end
    repeat (2 * B) @(negedge clk);
    checks++; if (cmd_sent !== 1'b1) begin errors++; $display("FAIL cmd_sent_hold: got %b, expected 1", cmd_sent); end
    compare_tx_bytes(2);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL tx_idle: got %b, expected 1", TX); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    int rises0;
    rises0 = cs_rises;
    exp_q.push_back({1'b1, 8'h47});
    exp_q.push_back({1'b1, 8'hF1});
    pulse_send(16'h47F1);
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL cmd_sent_clear: got %b, expected 0", cmd_sent); end
    repeat (5 * B) @(negedge clk);
    pulse_send(16'h1234);
    repeat (8 * B) @(negedge clk);
    pulse_send(16'h1234);
    cnt = 0;
    while (cmd_sent !== 1'b1 && cnt < 30 * B) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt >= 30 * B) begin errors++; $display("FAIL b2b_timeout: cmd_sent=%b, expected 1", cmd_sent); end
    repeat (12 * B) @(negedge clk);
    compare_tx_bytes(2);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra_frames: got %0d, expected 0", obs_q.size()); end
    checks++; if (cs_rises - rises0 != 1) begin errors++; $display("FAIL b2b_cmd_sent_rises: got %0d, expected 1", cs_rises - rises0); end
  endtask

  task automatic test_rx_ack();
    logic [7:0] got, exp;
    int p0;
    p0 = rdy_pulses;
    rdy_max = 0;
    resp_exp_q.push_back(8'hA5);
    drive_rx(8'hA5, 1'b1);
    repeat (2 * B) @(negedge clk);
    checks++; if (rdy_pulses - p0 != 1) begin errors++; $display("FAIL rx_ack_pulses: got %0d, expected 1", rdy_pulses - p0); end
    checks++; if (rdy_max != 1) begin errors++; $display("FAIL rx_ack_width: got %0d, expected 1", rdy_max); end
    exp = resp_exp_q.pop_front();
    checks++;
    if (resp_obs_q.size() == 0) begin
      errors++; $display("FAIL rx_ack_resp: no byte received, expected %h", exp);
    end else begin
      got = resp_obs_q.pop_front();
      if (got !== exp) begin errors++; $display("FAIL rx_ack_resp: got %h, expected %h", got, exp); end
    end
    checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL rx_ack_hold: got %h, expected a5", resp); end
  endtask

  task automatic test_rx_framing();
    int p0;
    p0 = rdy_pulses;
    drive_rx(8'h5A, 1'b0);
    repeat (2 * B) @(negedge clk);
    checks++; if (rdy_pulses != p0) begin errors++; $display("FAIL rx_frame_err_rdy: got %0d pulses, expected 0", rdy_pulses - p0); end
    checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL rx_frame_err_resp: got %h, expected a5", resp); end
    resp_exp_q.push_back(8'h3C);
    drive_rx(8'h3C, 1'b1);
    repeat (2 * B) @(negedge clk);
    checks++; if (resp !== resp_exp_q.pop_front()) begin errors++; $display("FAIL rx_recover: got %h, expected 3c", resp); end
    void'(resp_obs_q.pop_front());
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    pulse_send(16'hABCD);
    repeat (B / 4) @(negedge clk);
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL mid_frame_start: got %b, expected 0", TX); end
    rst = 1'b1;
    #1;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL mid_frame_tx: got %b, expected 1", TX); end
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL mid_frame_cmd_sent: got %b, expected 0", cmd_sent); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 25 * B; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL post_reset_tx_activity: got %0d low cycles, expected 0", lows); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL post_reset_frames: got %0d, expected 0", obs_q.size()); end
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL post_reset_cmd_sent: got %b, expected 0", cmd_sent); end
  endtask

  initial begin
    test_reset();
    test_send_cmd();
    test_rx_ack();
    test_back_to_back();
    test_rx_framing();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
